pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries N_DATA data words plus a packed control bundle between two pipeline stages.
- Adds valid/ready flow control, an optional 2-entry skid buffer, synchronous flush (bubble insertion) and saturating stall/bubble counters for the hazard unit and debug.
- One instance replaces each hand-written stage register in the 5-stage CPU.

Parameters:
- DATA_W, 32: width of each data word (Rs, Rt, Imm32, inst, npc, ...).
- N_DATA, 5: number of data words carried.
- CTRL_W, 11: packed control width, e.g. WB 3 + MA 4 + EX 4.
- SKID, 1: 1 = registered in_ready via skid entry; 0 = single register, combinational ready.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries (branch/jump taken).
- in_valid  in  1  upstream stage has a valid instruction.
- in_ready  out  1  this stage accepts in_data/in_ctrl this cycle.
- in_data  in  N_DATA*DATA_W  packed data words, word k at [k*DATA_W +: DATA_W].
- in_ctrl  in  CTRL_W  packed control bundle.
- out_valid  out  1  out_data/out_ctrl hold a valid instruction.
- out_ready  in  1  downstream consumes this cycle (0 = stall).
- out_data  out  N_DATA*DATA_W  registered data.
- out_ctrl  out  CTRL_W  registered control; forced to 0 whenever out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- bubble_cnt  out  CNT_W  cycles with out_valid=0, saturating.

Behaviour:
- Reset (async): all outputs, main/skid registers, valids and counters = 0. in_ready = 1 in the first cycle after reset deassertion.
- Transfers:
  - in_xfer = in_valid & in_ready.
  - out_xfer = out_valid & out_ready.
  - Latency: 1 cycle from in_xfer to out_valid when the stage is empty.
- SKID=1, states on {main_v, skid_v}:
  - EMPTY {0,0}: in_xfer loads main -> ONE.
  - ONE {1,0}:
    - in_xfer & out_xfer: main <= input, stay ONE.
    - in_xfer & ~out_xfer: skid <= input -> FULL.
    - ~in_xfer & out_xfer -> EMPTY.
  - FULL {1,1}: in_ready = 0. out_xfer: main <= skid -> ONE.
  - {0,1} is illegal and must never be reached (assertion).
  - in_ready = ~skid_v, a direct register output with no combinational path from out_ready.
  - Ordering is preserved: skid content always leaves before any newer input.
- SKID=0:
  - Single register. in_ready = out_ready | ~out_valid (combinational).
  - in_xfer loads main. out_xfer without in_xfer clears main_v.
- Flush:
  - Next cycle main_v = skid_v = 0 and out_ctrl = 0.
  - Data registers hold their old value.
  - Flush dominates a simultaneous in_xfer: the input is dropped.
  - The in_ready value in the flush cycle is unchanged; the upstream stage is flushed by the same hazard unit.
- Counters:
  - Update every cycle, including flush cycles, from the current (pre-edge) out_valid/out_ready.
  - Saturate at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- out_data is stable while out_valid & ~out_ready; the same holds for out_ctrl.
- Reset asserted mid-operation discards all contents immediately (async); no partial transfer completes.

Decomposition:
- Shared package pipe_pkg holds:
  - field widths and offsets: WB_W=3, MA_W=4, EX_W=4, CTRL_W derived;
  - data word index constants: IDX_RS=0, IDX_RT=1, IDX_IMM=2, IDX_INST=3, IDX_NPC=4;
  - the sat_inc function.
- One natural sub-module, sat_counter (width CNT_W, enable input), instantiated twice.
- The skid logic stays inline under a SKID generate.

Test Plan:
- Reset then in_valid=1, in_data word0=0x00000011, in_ctrl=0x7FF, out_ready=1: out_valid=1 next cycle, word0=0x11, out_ctrl=0x7FF.
- Backpressure (SKID=1): inputs A=0x1, B=0x2, C=0x3 on consecutive cycles with out_ready=0 from cycle 1:
  - in_ready=0 after B is taken;
  - out holds A;
  - out_ready=1 drains A, B in order; C is accepted only after in_ready returns to 1.
- Flush with FULL occupancy and a simultaneous in_valid: next cycle out_valid=0, out_ctrl=0, the input is dropped, in_ready=1.
- Stream of 8 words with out_ready=1 every cycle: 8 outputs at 1-cycle latency, stall_cnt=0, throughput 1/cycle.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles: stall_cnt saturates at 15.
- SKID=0 build: out_ready=0 with out_valid=1 forces in_ready=0 in the same cycle; async rst pulse mid-stream clears out_valid and both counters immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised inter-stage pipeline register:
// control bundle layout, data word slots, occupancy encoding and counter helper.
package pipe_pkg;

    localparam int WB_W   = 3;
    localparam int MA_W   = 4;
    localparam int EX_W   = 4;
    localparam int CTRL_W = WB_W + MA_W + EX_W;

    localparam int EX_OFF = 0;
    localparam int MA_OFF = EX_OFF + EX_W;
    localparam int WB_OFF = MA_OFF + MA_W;

    localparam int IDX_RS   = 0;
    localparam int IDX_RT   = 1;
    localparam int IDX_IMM  = 2;
    localparam int IDX_INST = 3;
    localparam int IDX_NPC  = 4;

    // Occupancy encoded as {main_v, skid_v}; 2'b01 is deliberately not a state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b10,
        OCC_FULL  = 2'b11
    } occ_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter (CNT_W up to 32), cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    import pipe_pkg::*;

    localparam logic [31:0] MAX_V = (32'd1 << CNT_W) - 32'd1;

    logic at_max;

    // sat_inc leaves the value unchanged only once the ceiling is reached.
    assign at_max = (sat_inc(32'(count), MAX_V) == 32'(count));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, synchronous flush and saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int N_DATA = 5,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_DATA*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]        in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_DATA*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
);
    import pipe_pkg::*;

    localparam int DW = N_DATA * DATA_W;

    logic              main_v;
    logic [DW-1:0]     main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = main_v & out_ready;
    assign out_valid = main_v;
    assign out_data  = main_data;
    assign out_ctrl  = main_v ? main_ctrl : '0;

    generate
        if (SKID != 0) begin : g_skid
            occ_e              state_q;
            occ_e              state_d;
            logic              skid_v;
            logic [DW-1:0]     skid_data;
            logic [CTRL_W-1:0] skid_ctrl;
            logic              ld_main_in;
            logic              ld_main_skid;
            logic              ld_skid;

            assign {main_v, skid_v} = state_q;
            assign in_ready         = ~skid_v;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= OCC_EMPTY;
                end else begin
                    state_q <= state_d;
                end
            end

            // Flush wins over everything: drop the input and keep data untouched.
            always_comb begin
                state_d      = state_q;
                ld_main_in   = 1'b0;
                ld_main_skid = 1'b0;
                ld_skid      = 1'b0;
                case (state_q)
                    OCC_EMPTY: begin
                        if (in_xfer) begin
                            ld_main_in = 1'b1;
                            state_d    = OCC_ONE;
                        end
                    end
                    OCC_ONE: begin
                        if (in_xfer && out_xfer) begin
                            ld_main_in = 1'b1;
                        end else if (in_xfer) begin
                            ld_skid = 1'b1;
                            state_d = OCC_FULL;
                        end else if (out_xfer) begin
                            state_d = OCC_EMPTY;
                        end
                    end
                    OCC_FULL: begin
                        if (out_xfer) begin
                            ld_main_skid = 1'b1;
                            state_d      = OCC_ONE;
                        end
                    end
                    default: state_d = OCC_EMPTY;
                endcase
                if (flush) begin
                    state_d      = OCC_EMPTY;
                    ld_main_in   = 1'b0;
                    ld_main_skid = 1'b0;
                    ld_skid      = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_data <= '0;
                    main_ctrl <= '0;
                    skid_data <= '0;
                    skid_ctrl <= '0;
                end else begin
                    if (ld_main_in) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (ld_main_skid) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                    if (ld_skid) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                    end
                end
            end

            a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst)
                                               !(skid_v && !main_v));
        end else begin : g_noskid
            assign in_ready = out_ready | ~main_v;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    main_v    <= 1'b0;
                    main_data <= '0;
                    main_ctrl <= '0;
                end else if (flush) begin
                    main_v <= 1'b0;
                end else if (in_xfer) begin
                    main_v    <= 1'b1;
                    main_data <= in_data;
                    main_ctrl <= in_ctrl;
                end else if (out_xfer) begin
                    main_v <= 1'b0;
                end
            end
        end
    endgenerate

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (main_v & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (~main_v),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid build, 4-bit counter build and
// single-register build share one input stimulus.
module tb_pipe_stage_reg;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [159:0] in_data;
    logic [10:0]  in_ctrl;
    logic         out_ready;

    logic         s1_in_ready, s1_out_valid;
    logic [159:0] s1_out_data;
    logic [10:0]  s1_out_ctrl;
    logic [15:0]  s1_stall, s1_bubble;

    logic         s4_in_ready, s4_out_valid;
    logic [159:0] s4_out_data;
    logic [10:0]  s4_out_ctrl;
    logic [3:0]   s4_stall, s4_bubble;

    logic         s0_in_ready, s0_out_valid;
    logic [159:0] s0_out_data;
    logic [10:0]  s0_out_ctrl;
    logic [15:0]  s0_stall, s0_bubble;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        iv;
        logic [31:0] d0;
        logic [10:0] c;
        logic        rdy;
        logic        fl;
        logic        ov;
        logic [31:0] w;
        logic [10:0] ec;
        logic        ir;
    } vec_t;

    vec_t vecs[13];

    pipe_stage_reg #(.SKID(1), .CNT_W(16)) dut_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s1_out_valid), .out_ready(out_ready),
        .out_data(s1_out_data), .out_ctrl(s1_out_ctrl), .stall_cnt(s1_stall), .bubble_cnt(s1_bubble)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) dut_cnt4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s4_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s4_out_valid), .out_ready(out_ready),
        .out_data(s4_out_data), .out_ctrl(s4_out_ctrl), .stall_cnt(s4_stall), .bubble_cnt(s4_bubble)
    );

    pipe_stage_reg #(.SKID(0), .CNT_W(16)) dut_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s0_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(s0_out_valid), .out_ready(out_ready),
        .out_data(s0_out_data), .out_ctrl(s0_out_ctrl), .stall_cnt(s0_stall), .bubble_cnt(s0_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int iv, input int d0, input int c, input int rdy,
                                input int fl, input int ov, input int w, input int ec,
                                input int ir);
        vec_t v;
        v.iv  = iv[0];
        v.d0  = d0;
        v.c   = c[10:0];
        v.rdy = rdy[0];
        v.fl  = fl[0];
        v.ov  = ov[0];
        v.w   = w;
        v.ec  = ec[10:0];
        v.ir  = ir[0];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and leave time just past the edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] d0, input logic [10:0] c,
                                 input logic rdy, input logic fl);
        in_valid  = iv;
        in_ctrl   = c;
        out_ready = rdy;
        flush     = fl;
        for (int k = 0; k < 5; k++) in_data[k*32 +: 32] = d0 + 32'(k * 16);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(1, 32'h11, 11'h7FF, 1, 0, 1, 32'h11, 11'h7FF, 1);
        vecs[1]  = mk(0, 0,      0,       1, 0, 0, 0,      0,       1);
        vecs[2]  = mk(1, 1,      1,       0, 0, 1, 1,      1,       1);
        vecs[3]  = mk(1, 2,      2,       0, 0, 1, 1,      1,       0);
        vecs[4]  = mk(1, 3,      3,       0, 0, 1, 1,      1,       0);
        vecs[5]  = mk(1, 3,      3,       1, 0, 1, 2,      2,       1);
        vecs[6]  = mk(1, 3,      3,       1, 0, 1, 3,      3,       1);
        vecs[7]  = mk(0, 0,      0,       1, 0, 0, 0,      0,       1);
        vecs[8]  = mk(1, 4,      4,       0, 0, 1, 4,      4,       1);
        vecs[9]  = mk(1, 5,      5,       0, 0, 1, 4,      4,       0);
        vecs[10] = mk(1, 6,      6,       0, 1, 0, 0,      0,       1);
        vecs[11] = mk(1, 7,      7,       1, 1, 0, 0,      0,       1);
        vecs[12] = mk(0, 0,      0,       1, 0, 0, 0,      0,       1);

        doReset();
        checkOutput("reset out_valid", 32'(s1_out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(s1_in_ready), 32'd1);
        checkOutput("reset out_ctrl", 32'(s1_out_ctrl), 32'd0);
        checkOutput("reset out_data word0", s1_out_data[31:0], 32'd0);
        checkOutput("reset stall_cnt", 32'(s1_stall), 32'd0);
        checkOutput("reset bubble_cnt", 32'(s1_bubble), 32'd0);

        // Single transfer, backpressure through the skid entry, then flush cases.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].d0, vecs[i].c, vecs[i].rdy, vecs[i].fl);
            checkOutput($sformatf("vec%0d out_valid", i), 32'(s1_out_valid), 32'(vecs[i].ov));
            if (vecs[i].ov) begin
                checkOutput($sformatf("vec%0d word0", i), s1_out_data[31:0], vecs[i].w);
                checkOutput($sformatf("vec%0d word4", i), s1_out_data[159:128], vecs[i].w + 32'd64);
            end
            checkOutput($sformatf("vec%0d out_ctrl", i), 32'(s1_out_ctrl), 32'(vecs[i].ec));
            checkOutput($sformatf("vec%0d in_ready", i), 32'(s1_in_ready), 32'(vecs[i].ir));
        end

        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 11'(i), 1'b1, 1'b0);
            checkOutput($sformatf("stream%0d out_valid", i), 32'(s1_out_valid), 32'd1);
            checkOutput($sformatf("stream%0d word0", i), s1_out_data[31:0], 32'h100 + 32'(i));
            checkOutput($sformatf("stream%0d out_ctrl", i), 32'(s1_out_ctrl), 32'(i));
            checkOutput($sformatf("stream%0d in_ready", i), 32'(s1_in_ready), 32'd1);
        end
        checkOutput("stream stall_cnt", 32'(s1_stall), 32'd0);

        doReset();
        applyStimulus(1'b1, 32'h9, 11'h9, 1'b0, 1'b0);
        checkOutput("sat load out_valid", 32'(s4_out_valid), 32'd1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 11'h0, 1'b0, 1'b0);
        checkOutput("sat stall4 after 10", 32'(s4_stall), 32'd10);
        checkOutput("sat stall16 after 10", 32'(s1_stall), 32'd10);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 11'h0, 1'b0, 1'b0);
        checkOutput("sat stall4 after 20", 32'(s4_stall), 32'd15);
        checkOutput("sat stall16 after 20", 32'(s1_stall), 32'd20);
        checkOutput("sat bubble4", 32'(s4_bubble), 32'd1);
        checkOutput("sat held word0", s4_out_data[31:0], 32'h9);
        checkOutput("sat held out_ctrl", 32'(s4_out_ctrl), 32'h9);

        // Single-register build: combinational ready, then an asynchronous reset pulse.
        doReset();
        applyStimulus(1'b1, 32'h21, 11'h15, 1'b1, 1'b0);
        checkOutput("noskid out_valid", 32'(s0_out_valid), 32'd1);
        checkOutput("noskid word0", s0_out_data[31:0], 32'h21);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        checkOutput("noskid in_ready stalled", 32'(s0_in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        checkOutput("noskid in_ready consuming", 32'(s0_in_ready), 32'd1);
        applyStimulus(1'b1, 32'h22, 11'h16, 1'b0, 1'b0);
        checkOutput("noskid held word0", s0_out_data[31:0], 32'h21);
        checkOutput("noskid held out_ctrl", 32'(s0_out_ctrl), 32'h15);
        checkOutput("noskid stall_cnt", 32'(s0_stall), 32'd1);
        checkOutput("noskid bubble_cnt", 32'(s0_bubble), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst out_valid", 32'(s0_out_valid), 32'd0);
        checkOutput("async rst out_ctrl", 32'(s0_out_ctrl), 32'd0);
        checkOutput("async rst stall_cnt", 32'(s0_stall), 32'd0);
        checkOutput("async rst bubble_cnt", 32'(s0_bubble), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
